aitl_top_ctrl: RTL and testbench
================================

// Module: aitl_top_ctrl
// PURPOSE
//   Unified AITL control block: 3-state mode FSM plus registered 8-bit PID loop.
//   input_signal is the mode command; sensor_input is the plant measurement.
//   The PID runs only in TRACK/RECOVERY. In IDLE it is parked.
//   Top-level PoC block; drives fsm_state and pid_output to the system.
// PARAMETERS
//   SETPOINT  80   unsigned 8-bit regulation target
//   KP        2    proportional gain, signed integer
//   KI        1    integral gain, signed integer
//   KD        1    derivative gain, signed integer
//   SHIFT     0    arithmetic right shift applied to PID sum (floor)
//   BIAS      128  output offset added after shift
//   INT_LIM   255  symmetric integrator clamp, +/-INT_LIM
// PORTS
//   clk           in   1  single clock, rising edge
//   reset         in   1  asynchronous, active-high reset
//   input_signal  in   2  mode command; 0=none, 1=track, 2=recover, 3=idle
//   sensor_input  in   8  unsigned measurement
//   fsm_state     out  2  registered state; 0=IDLE, 1=TRACK, 2=RECOVERY
//   pid_output    out  8  registered unsigned actuator command
// BEHAVIOUR
//   Reset (async, immediate):
//     fsm_state=IDLE(0), pid_output=0, integ=0, e_prev=0.
//   FSM, evaluated on each rising edge from current state and input_signal:
//     IDLE:     1->TRACK; else stay.
//     TRACK:    2->RECOVERY; 3->IDLE (abort); else stay.
//     RECOVERY: 3->IDLE; 1->TRACK; else stay.
//     Encoding 3 is illegal and goes to IDLE on the next edge.
//   PID datapath:
//     e = SETPOINT - sensor_input, 9-bit signed, range -255..255.
//     PID mode is selected by the CURRENT (pre-edge) state, not next state.
//     So the first PID update happens one edge after entering TRACK.
//   In IDLE, each edge:
//     integ<=0; e_prev<=e; pid_output<=0.
//     Loading e_prev avoids a derivative kick on entry.
//   In TRACK or RECOVERY, each edge (same gains in both):
//     integ_n = clamp(integ+e, -INT_LIM, +INT_LIM)
//     u = (KP*e + KI*integ_n + KD*(e-e_prev)) >>> SHIFT, 16-bit signed
//     pid_output <= clamp(u+BIAS, 0, 255); integ<=integ_n; e_prev<=e
//   Timing and arithmetic rules:
//     Latency: sensor to pid_output is 1 edge. Command to fsm_state is 1 edge.
//     No handshake: inputs are sampled every edge; hold 0 to keep the mode.
//     Saturation: the output clamps at 0 and 255 with no wrap.
//     The integrator clamps at +/-INT_LIM (anti-windup).
//     All arithmetic is signed and sized so intermediates never overflow.
//   Reset asserted mid-operation returns all registers to reset values at once.
// TESTING
//   1 Reset, cmd=0, sensor=80 -> fsm_state=0, pid_output=0.
//     Holding cmd 0 keeps both at 0.
//   2 After reset release: cmd=1, sensor=85 for 2 edges -> fsm_state=1, pid_output=113.
//     Edge 1: IDLE->TRACK, output 0. Edge 2: e=-5, integ=-5, d=0.
//   3 Then cmd=2, sensor=70 for 2 edges -> fsm_state=2, pid_output=163.
//     Edge 1: output 168. Edge 2: integ=15.
//   4 Then cmd=3, sensor=90 for 2 edges -> fsm_state=0, pid_output=0.
//     Edge 1: output 93, state->IDLE. Edge 2: integ cleared.
//   5 TRACK with sensor=0 for 300 edges -> integ pinned at 255, pid_output=255.
//     Also TRACK with sensor=255 -> pid_output=0 (saturation).
//   6 Assert reset between clock edges while in RECOVERY.
//     -> fsm_state=0 and pid_output=0 immediately, before the next edge.

Source files
------------

// File: rtl/aitl_top_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aitl_top_ctrl
//  Brief    : AITL control block: 3-state mode FSM with registered 8-bit PID
//  Revision : 1.0  initial release
// ============================================================================
module aitl_top_ctrl #(
   parameter logic [7:0] SETPOINT = 8'd80,
   parameter int         KP       = 2,
   parameter int         KI       = 1,
   parameter int         KD       = 1,
   parameter int         SHIFT    = 0,
   parameter int         BIAS     = 128,
   parameter int         INT_LIM  = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] input_signal,
   input  logic [7:0] sensor_input,
   output logic [1:0] fsm_state,
   output logic [7:0] pid_output
);

   localparam int c_int_w = $clog2(INT_LIM + 1) + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TRACK    = 2'd1,
      ST_RECOVERY = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic signed [c_int_w-1:0]  r_integ;
   logic signed [8:0]          r_e_prev;
   logic        [7:0]          r_pid_out;

   logic signed [31:0] w_e;
   logic signed [31:0] w_integ_sum;
   logic signed [31:0] w_integ_n;
   logic signed [31:0] w_e_prev_ext;
   logic signed [31:0] w_pid_sum;
   logic signed [31:0] w_u;
   logic signed [31:0] w_out_sum;
   logic        [7:0]  w_out_sat;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Command 0 holds the current mode; an undefined state falls back to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (input_signal == 2'd1) w_state_nxt = ST_TRACK;
         end
         ST_TRACK: begin
            if (input_signal == 2'd2)      w_state_nxt = ST_RECOVERY;
            else if (input_signal == 2'd3) w_state_nxt = ST_IDLE;
         end
         ST_RECOVERY: begin
            if (input_signal == 2'd3)      w_state_nxt = ST_IDLE;
            else if (input_signal == 2'd1) w_state_nxt = ST_TRACK;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath is carried at 32 bits so no intermediate can overflow.
   always_comb begin
      w_e          = $signed({24'd0, SETPOINT}) - $signed({24'd0, sensor_input});
      w_integ_sum  = $signed({{(32 - c_int_w){r_integ[c_int_w-1]}}, r_integ}) + w_e;
      w_e_prev_ext = $signed({{23{r_e_prev[8]}}, r_e_prev});

      w_integ_n = w_integ_sum;
      if (w_integ_sum > INT_LIM)       w_integ_n = INT_LIM;
      else if (w_integ_sum < -INT_LIM) w_integ_n = -INT_LIM;

      w_pid_sum = KP * w_e + KI * w_integ_n + KD * (w_e - w_e_prev_ext);
      w_u       = w_pid_sum >>> SHIFT;
      w_out_sum = w_u + BIAS;

      w_out_sat = w_out_sum[7:0];
      if (w_out_sum < 0)        w_out_sat = 8'd0;
      else if (w_out_sum > 255) w_out_sat = 8'd255;
   end

   // Mode is taken from the pre-edge state; IDLE preloads e_prev to avoid a derivative kick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_integ   <= '0;
         r_e_prev  <= '0;
         r_pid_out <= '0;
      end else if (r_state == ST_IDLE) begin
         r_integ   <= '0;
         r_e_prev  <= w_e[8:0];
         r_pid_out <= '0;
      end else begin
         r_integ   <= w_integ_n[c_int_w-1:0];
         r_e_prev  <= w_e[8:0];
         r_pid_out <= w_out_sat;
      end
   end

   assign fsm_state  = r_state;
   assign pid_output = r_pid_out;

endmodule
`default_nettype wire

// File: tb/tb_aitl_top_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aitl_top_ctrl
//  Brief    : Self-checking bench for aitl_top_ctrl against a behavioural model
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aitl_top_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] input_signal = 2'd0;
   logic [7:0] sensor_input = 8'd80;
   logic [1:0] fsm_state;
   logic [7:0] pid_output;

   int checks = 0;
   int errors = 0;

   // Behavioural model: mode number, integrator, previous error, output.
   int m_mode, m_integ, m_eprev, m_out;
   int next_mode [3][4] = '{'{0, 1, 0, 0}, '{1, 1, 2, 0}, '{2, 1, 2, 0}};

   aitl_top_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .input_signal (input_signal),
      .sensor_input (sensor_input),
      .fsm_state    (fsm_state),
      .pid_output   (pid_output)
   );

   always #5 clk = ~clk;

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_integ = 0; m_eprev = 0; m_out = 0;
   endtask

   task automatic model_step(input int cmd, input int sensor);
      int e, u;
      e = 80 - sensor;
      if (m_mode == 0) begin
         m_integ = 0;
         m_out   = 0;
      end else begin
         m_integ = clampi(m_integ + e, -255, 255);
         u       = (2 * e + m_integ + (e - m_eprev)) >>> 0;
         m_out   = clampi(u + 128, 0, 255);
      end
      m_eprev = e;
      m_mode  = next_mode[m_mode][cmd];
   endtask

   // Apply inputs at the falling edge, advance the model, sample 1ns after the rise.
   task automatic drive_edge(input int cmd, input int sensor);
      @(negedge clk);
      input_signal = 2'(cmd);
      sensor_input = 8'(sensor);
      @(posedge clk);
      model_step(cmd, sensor);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      input_signal = 2'd0;
      sensor_input = 8'd80;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (fsm_state !== 2'd0 || pid_output !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: state=%0d out=%0d, required state=0 out=0", fsm_state, pid_output);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_edge(0, 80);
         checks++;
         if (fsm_state !== 2'd0 || pid_output !== 8'd0) begin
            errors++;
            $display("FAIL hold_idle[%0d]: state=%0d out=%0d, required state=0 out=0", i, fsm_state, pid_output);
         end
      end
   endtask

   task automatic test_mode_sequence();
      int cmd_t [6] = '{1, 1, 2, 2, 3, 3};
      int sen_t [6] = '{85, 85, 70, 70, 90, 90};
      int st_t  [6] = '{1, 1, 2, 2, 0, 0};
      int out_t [6] = '{0, 113, 168, 163, 93, 0};
      for (int i = 0; i < 6; i++) begin
         drive_edge(cmd_t[i], sen_t[i]);
         checks++;
         if (fsm_state !== 2'(st_t[i]) || pid_output !== 8'(out_t[i])) begin
            errors++;
            $display("FAIL mode_seq[%0d]: state=%0d out=%0d, required state=%0d out=%0d",
                     i, fsm_state, pid_output, st_t[i], out_t[i]);
         end
      end
   endtask

   task automatic test_saturation();
      int bad;
      drive_edge(1, 0);
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         drive_edge(0, 0);
         checks++;
         if (pid_output !== 8'(m_out) || fsm_state !== 2'd1) begin
            errors++;
            $display("FAIL sat_high[%0d]: state=%0d out=%0d, required state=1 out=%0d", i, fsm_state, pid_output, m_out);
         end
      end
      checks++;
      if (pid_output !== 8'd255 || m_integ != 255) begin
         errors++;
         $display("FAIL sat_high_final: out=%0d, required 255 (model integ %0d)", pid_output, m_integ);
      end
      // Small negative error bleeds the pinned integrator down one step per edge.
      for (int i = 0; i < 200; i++) begin
         drive_edge(0, 81);
         checks++;
         if (pid_output !== 8'(m_out)) begin
            errors++;
            $display("FAIL integ_bleed[%0d]: out=%0d, required %0d", i, pid_output, m_out);
         end
      end
      for (int i = 0; i < 50; i++) drive_edge(0, 255);
      checks++;
      if (pid_output !== 8'd0 || fsm_state !== 2'd1) begin
         errors++;
         $display("FAIL sat_low: state=%0d out=%0d, required state=1 out=0", fsm_state, pid_output);
      end
   endtask

   task automatic test_random();
      int cmd, sen;
      for (int i = 0; i < 600; i++) begin
         cmd = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
         case ($urandom_range(0, 7))
            0:       sen = 0;
            1:       sen = 255;
            default: sen = int'($urandom_range(40, 120));
         endcase
         drive_edge(cmd, sen);
         checks++;
         if (fsm_state !== 2'(m_mode) || pid_output !== 8'(m_out)) begin
            errors++;
            $display("FAIL random[%0d] cmd=%0d sen=%0d: state=%0d out=%0d, required state=%0d out=%0d",
                     i, cmd, sen, fsm_state, pid_output, m_mode, m_out);
         end
      end
   endtask

   task automatic test_async_reset();
      drive_edge(3, 80);
      drive_edge(1, 70);
      drive_edge(2, 70);
      drive_edge(0, 60);
      checks++;
      if (fsm_state !== 2'd2 || pid_output === 8'd0) begin
         errors++;
         $display("FAIL pre_reset_recovery: state=%0d out=%0d, required state=2 out=%0d", fsm_state, pid_output, m_out);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (fsm_state !== 2'd0 || pid_output !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: state=%0d out=%0d, required state=0 out=0", fsm_state, pid_output);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      drive_edge(1, 85);
      drive_edge(0, 85);
      checks++;
      if (fsm_state !== 2'd1 || pid_output !== 8'd113) begin
         errors++;
         $display("FAIL post_reset_track: state=%0d out=%0d, required state=1 out=113", fsm_state, pid_output);
      end
   endtask

   initial begin
      test_reset();
      test_mode_sequence();
      test_saturation();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
